// File: rtl/demux_pkg.sv
//------------------------------------------------------------------------------
// demux_pkg : shared constants and helpers for the 1x2 demux FIFO.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package demux_pkg;

   localparam int DEFAULT_DATA_WIDTH = 2;
   localparam int DEFAULT_FIFO_DEPTH = 4;

   localparam logic LANE0 = 1'b0;
   localparam logic LANE1 = 1'b1;

   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

`default_nettype wire

// File: rtl/demux_lane_fifo.sv
//------------------------------------------------------------------------------
// demux_lane_fifo : first-word-fall-through lane FIFO with masked head output.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module demux_lane_fifo
   import demux_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] head_data_o,
   output logic                  full_o
);

   localparam int PW = ptr_width(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  push_ok;
   logic                  pop_ok;

   assign valid_o     = (count_q != '0);
   assign full_o      = (count_q == CW'(FIFO_DEPTH));
   // Head is forced to zero while empty so stale memory never leaks out.
   assign head_data_o = valid_o ? mem_q[rd_ptr_q] : '0;

   always_comb begin
      push_ok  = push_i && !full_o;
      pop_ok   = pop_i && valid_o;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

`default_nettype wire

// File: rtl/demux_memoria1x2_fifo.sv
//------------------------------------------------------------------------------
// demux_memoria1x2_fifo : steers a valid-tagged stream into two buffered lanes.
// Optional DEMUX_AUTO_SEL_EN replaces selector with a strict 0/1 alternation.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module demux_memoria1x2_fifo
   import demux_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  valid_input,
   input  logic                  selector,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  ready_output,
   output logic                  valid_out0,
   output logic                  valid_out1,
   output logic [DATA_WIDTH-1:0] data_out0,
   output logic [DATA_WIDTH-1:0] data_out1,
   input  logic                  ready_in0,
   input  logic                  ready_in1,
   output logic                  full0,
   output logic                  full1
);

   logic lane_sel;
   logic push_acc;
   logic push0;
   logic push1;

`ifdef DEMUX_AUTO_SEL_EN
   logic toggle_q, toggle_d;
   logic unused_selector;

   assign unused_selector = selector;
   assign lane_sel        = toggle_q;
   // A stalled word keeps its lane; only accepted pushes advance the toggle.
   assign toggle_d        = push_acc ? ~toggle_q : toggle_q;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) toggle_q <= 1'b0;
      else          toggle_q <= toggle_d;
   end
`else
   assign lane_sel = selector;
`endif

   assign ready_output = (lane_sel == LANE1) ? !full1 : !full0;
   assign push_acc     = valid_input && ready_output;
   assign push0        = push_acc && (lane_sel == LANE0);
   assign push1        = push_acc && (lane_sel == LANE1);

   demux_lane_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_lane0 (
      .clk         (clk),
      .reset_L     (reset_L),
      .push_i      (push0),
      .push_data_i (data_in),
      .pop_i       (ready_in0),
      .valid_o     (valid_out0),
      .head_data_o (data_out0),
      .full_o      (full0)
   );

   demux_lane_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_lane1 (
      .clk         (clk),
      .reset_L     (reset_L),
      .push_i      (push1),
      .push_data_i (data_in),
      .pop_i       (ready_in1),
      .valid_o     (valid_out1),
      .head_data_o (data_out1),
      .full_o      (full1)
   );

endmodule

`default_nettype wire

// File: tb/tb_demux_memoria1x2_fifo.sv
//------------------------------------------------------------------------------
// tb_demux_memoria1x2_fifo : queue-model scoreboard plus directed literal checks.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_demux_memoria1x2_fifo;

   logic       clk = 1'b0;
   logic       reset_L;
   logic       valid_input;
   logic       selector;
   logic [1:0] data_in;
   logic       ready_output;
   logic       valid_out0, valid_out1;
   logic [1:0] data_out0, data_out1;
   logic       ready_in0, ready_in1;
   logic       full0, full1;

   int n_checks = 0;
   int n_pass   = 0;

   logic [1:0] q0[$];
   logic [1:0] q1[$];
   bit         tog = 1'b0;

   always #5 clk = ~clk;

   demux_memoria1x2_fifo dut (
      .clk          (clk),
      .reset_L      (reset_L),
      .valid_input  (valid_input),
      .selector     (selector),
      .data_in      (data_in),
      .ready_output (ready_output),
      .valid_out0   (valid_out0),
      .valid_out1   (valid_out1),
      .data_out0    (data_out0),
      .data_out1    (data_out1),
      .ready_in0    (ready_in0),
      .ready_in1    (ready_in1),
      .full0        (full0),
      .full1        (full1)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   function automatic bit model_sel();
`ifdef DEMUX_AUTO_SEL_EN
      return tog;
`else
      return selector;
`endif
   endfunction

   // Scoreboard: update queues from the inputs at each edge, then compare.
   always @(posedge clk) begin
      bit sel, push;
      int sz;
      if (!reset_L) begin
         q0.delete();
         q1.delete();
         tog = 1'b0;
      end else begin
         sel  = model_sel();
         sz   = sel ? q1.size() : q0.size();
         push = valid_input && (sz < 4);
         if (ready_in0 && q0.size() > 0) void'(q0.pop_front());
         if (ready_in1 && q1.size() > 0) void'(q1.pop_front());
         if (push) begin
            if (sel) q1.push_back(data_in);
            else     q0.push_back(data_in);
            tog = ~tog;
         end
      end
      #1;
      chk("m_valid0", int'(valid_out0), int'(q0.size() != 0));
      chk("m_valid1", int'(valid_out1), int'(q1.size() != 0));
      chk("m_data0",  int'(data_out0),  (q0.size() != 0) ? int'(q0[0]) : 0);
      chk("m_data1",  int'(data_out1),  (q1.size() != 0) ? int'(q1[0]) : 0);
      chk("m_full0",  int'(full0),      int'(q0.size() == 4));
      chk("m_full1",  int'(full1),      int'(q1.size() == 4));
      sz = model_sel() ? q1.size() : q0.size();
      chk("m_ready",  int'(ready_output), int'(sz < 4));
   end

   logic [1:0] fill [4];

   initial begin
      fill = '{2'b01, 2'b10, 2'b11, 2'b00};
      reset_L = 1'b0; valid_input = 1'b0; selector = 1'b0; data_in = 2'b00;
      ready_in0 = 1'b0; ready_in1 = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("rst_ready",  int'(ready_output), 1);
      chk("rst_valid0", int'(valid_out0), 0);
      chk("rst_valid1", int'(valid_out1), 0);
      chk("rst_full0",  int'(full0), 0);
      chk("rst_full1",  int'(full1), 0);
      reset_L = 1'b1;
      @(negedge clk);

      // Single word into lane 1
      valid_input = 1'b1; selector = 1'b1; data_in = 2'b10;
      @(negedge clk);
      valid_input = 1'b0;
      chk("t1_valid1", int'(valid_out1), 1);
      chk("t1_data1",  int'(data_out1), 2);
      chk("t1_valid0", int'(valid_out0), 0);
      chk("t1_data0",  int'(data_out0), 0);
      ready_in1 = 1'b1;
      @(negedge clk);
      ready_in1 = 1'b0;
      chk("t1_drained", int'(valid_out1), 0);

      // Fill lane 0, ready depends on target lane, then drain in order
      selector = 1'b0; valid_input = 1'b1;
      for (int i = 0; i < 4; i++) begin data_in = fill[i]; @(negedge clk); end
      valid_input = 1'b0;
      chk("t2_full0", int'(full0), 1);
      #1 chk("t2_ready_sel0", int'(ready_output), 0);
      selector = 1'b1;
      #1 chk("t2_ready_sel1", int'(ready_output), 1);
      selector = 1'b0;
      ready_in0 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t2_drain", int'(data_out0), int'(fill[i]));
         @(negedge clk);
      end
      ready_in0 = 1'b0;
      chk("t2_empty", int'(valid_out0), 0);

      // Full lane: pop proceeds, same-cycle push refused
      valid_input = 1'b1;
      for (int i = 0; i < 4; i++) begin data_in = fill[i]; @(negedge clk); end
      data_in = 2'b11; ready_in0 = 1'b1;
      @(negedge clk);
      valid_input = 1'b0;
      chk("t3_full0", int'(full0), 0);
      chk("t3_head",  int'(data_out0), 2);
      for (int i = 1; i < 4; i++) begin
         chk("t3_drain", int'(data_out0), int'(fill[i]));
         @(negedge clk);
      end
      ready_in0 = 1'b0;
      chk("t3_empty", int'(valid_out0), 0);

      // Asynchronous reset with both lanes holding two words
      valid_input = 1'b1; selector = 1'b0;
      data_in = 2'b01; @(negedge clk);
      data_in = 2'b10; @(negedge clk);
      selector = 1'b1;
      data_in = 2'b11; @(negedge clk);
      data_in = 2'b00; @(negedge clk);
      valid_input = 1'b0;
      chk("t4_pre_v0", int'(valid_out0), 1);
      chk("t4_pre_v1", int'(valid_out1), 1);
      #2 reset_L = 1'b0;
      #1;
      chk("t4_valid0", int'(valid_out0), 0);
      chk("t4_valid1", int'(valid_out1), 0);
      chk("t4_data0",  int'(data_out0), 0);
      chk("t4_data1",  int'(data_out1), 0);
      chk("t4_full0",  int'(full0), 0);
      chk("t4_full1",  int'(full1), 0);
      chk("t4_ready",  int'(ready_output), 1);
      @(negedge clk);
      reset_L = 1'b1;
      @(negedge clk);

      // Pointer wrap on lane 1 with alternating push/pop
      selector = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) begin
            chk("t5_empty", int'(valid_out1), 0);
            valid_input = 1'b1; ready_in1 = 1'b0; data_in = 2'((i / 2) % 4);
         end else begin
            chk("t5_order", int'(data_out1), (i / 2) % 4);
            valid_input = 1'b0; ready_in1 = 1'b1;
         end
         @(negedge clk);
      end
      ready_in1 = 1'b0;

      // Mixed traffic, scoreboard only
      for (int i = 0; i < 80; i++) begin
         valid_input = 1'($urandom_range(0, 1));
         selector    = 1'($urandom_range(0, 1));
         data_in     = 2'($urandom_range(0, 3));
         ready_in0   = ($urandom_range(0, 3) == 0);
         ready_in1   = ($urandom_range(0, 2) == 0);
         @(negedge clk);
      end
      valid_input = 1'b0; ready_in0 = 1'b0; ready_in1 = 1'b0;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/demux_memoria1x2_fifo.md
# demux_memoria1x2_fifo

Routes a single valid-tagged data stream to one of two output lanes, buffering each lane in its own small FIFO. It sits downstream of the team's 2x1 registered multiplexers as the splitting end of the same valid-tagged 2-bit link. Backpressure runs upstream through a ready signal, and each lane drains independently through its own valid/ready handshake.

## Interface
- `DATA_WIDTH`, 2, width of every data word.
- `FIFO_DEPTH`, 4, entries per lane; power of two, ≥ 2.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `valid_input`  in  1  upstream word present.
- `selector`  in  1  target lane for the current word: 0 = lane 0, 1 = lane 1.
- `data_in`  in  DATA_WIDTH  upstream word.
- `ready_output`  out  1  block accepts the current word this cycle.
- `valid_out0`, `valid_out1`  out  1  lane holds a word (lane not empty).
- `data_out0`, `data_out1`  out  DATA_WIDTH  head word of each lane.
- `ready_in0`, `ready_in1`  in  1  downstream consumer takes the head word.
- `full0`, `full1`  out  1  lane holds FIFO_DEPTH words.

## Operation
- Target lane `lane_sel` = `selector`; under `DEMUX_AUTO_SEL_EN` it is the internal toggle bit.
- `ready_output` = !full of `lane_sel`, evaluated combinationally; it does not depend on `valid_input`.
- Push: `valid_input && ready_output` writes `data_in` into lane `lane_sel` at the write pointer, then advances the write pointer.
- Pop lane N: `valid_outN && ready_inN` advances the read pointer of lane N.
- Each lane is first-word-fall-through:
  - `valid_outN` = (countN != 0).
  - `data_outN` = memory[rd_ptrN] when valid, 2'b00 (all zeros) when empty.
- Count arithmetic per lane, width clog2(FIFO_DEPTH)+1:
  - push only: +1.
  - pop only: −1.
  - both: unchanged.
- Pointers are clog2(FIFO_DEPTH) bits and wrap naturally from FIFO_DEPTH−1 to 0.
- Full lane: a full lane never accepts a push, even when it is popped in the same cycle; there is no full-bypass.
- Push and pop on the other lane still proceed normally.
- Empty lane: `ready_inN` is ignored; there is no underflow and no state change.
- A word pushed into an empty lane is not visible in the same cycle; there is no combinational pass-through.
- `valid_input` low: no push, regardless of `selector`.
- Lanes are fully independent; simultaneous pops on both lanes plus a push on either lane are legal in one cycle.

## Timing
- Reset values (immediate on `reset_L` low, held until release):
  - all counts and pointers 0.
  - `valid_out0/1` = 0, `data_out0/1` = 0, `full0/1` = 0.
  - `ready_output` = 1.
  - toggle bit = 0.
- Reset mid-operation discards all buffered words. Memory contents need not be cleared, because `data_out` is masked while empty.
- Latency: a word accepted at edge k drives `valid_outN`/`data_outN` after edge k, provided the lane was empty.
- Throughput: one push per cycle, plus one pop per lane per cycle.
- `ready_output` reflects full status after the most recent edge; pops in the current cycle do not raise it until the next edge.

## Configuration
- `DEMUX_AUTO_SEL_EN` defined:
  - `selector` is ignored.
  - The internal toggle bit chooses the lane and flips on every accepted push, giving strict alternation lane 0, 1, 0, 1, ….
  - A stall (target lane full) does not flip the toggle; the next word waits for that same lane.
- `DEMUX_AUTO_SEL_EN` undefined: `selector` chooses the lane; the toggle register is not built.

## Structure
- Shared package `demux_pkg` holds:
  - default `DATA_WIDTH`/`FIFO_DEPTH` constants.
  - lane index constants `LANE0` = 0, `LANE1` = 1.
  - a pointer-width function (clog2).
- Sub-module `demux_lane_fifo`:
  - Interface: push, push_data, pop, valid, head_data, full.
  - Contains storage, pointers, count, and the data-out masking.
  - Instantiated twice.
- Top level holds only lane select, `ready_output`, push steering and the optional toggle.

## Test plan
- Reset, then `valid_input`=1, `selector`=1, `data_in`=2'b10 for one cycle, `ready_in1`=0 → after the edge, `valid_out1`=1, `data_out1`=2'b10; lane 0 stays `valid_out0`=0, `data_out0`=2'b00.
- Push 2'b01, 2'b10, 2'b11, 2'b00 to lane 0 with `ready_in0`=0 → `full0`=1; `ready_output`=0 while `selector`=0 and 1 while `selector`=1. Then drain with `ready_in0`=1 → `data_out0` reads 01, 10, 11, 00 over 4 cycles, then `valid_out0`=0.
- Lane 0 full, `valid_input`=1, `selector`=0, `ready_in0`=1 in the same cycle → the pop occurs, the push is refused, and the count goes 4→3.
- With `DEMUX_AUTO_SEL_EN`, push 2'b11, 2'b01, 2'b10 back-to-back with `selector` held at 1 → lane 0 receives 11 and 10, lane 1 receives 01.
- Lanes each hold 2 words; assert `reset_L`=0 asynchronously mid-cycle → outputs drop at once to `valid_out0/1`=0, `data_out0/1`=0, `full0/1`=0, `ready_output`=1.
- Wrap-around: 10 alternating push/pop cycles on lane 1 with `data_in` cycling 00..11 → `data_out1` order is preserved and the count never exceeds 1.
